hp_accumulator: RTL and testbench

Sequential reduction stage directly downstream of `hp_adder`. It takes a stream of half-precision operands and folds them into one running sum. Each beat goes through a single combinational `hp_adder` instance. After a programmed number of beats it presents the final sum with sticky exception flags on a valid/ready output port.

---
 rtl/hp_pkg.sv | 30 +++
 rtl/hp_accumulator_if.sv | 28 ++
 rtl/hp_adder.sv | 100 ++++++++++
 rtl/hp_accumulator.sv | 101 ++++++++++
 tb/tb_hp_accumulator.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hp_pkg.sv
// Shared half-precision constants, exception codes and accumulator states.
// Imported by the adder, the accumulator and its bus interface users.
package hp_pkg;

  localparam logic [15:0] HP_POS_INF = 16'h7C00;
  localparam logic [15:0] HP_NEG_INF = 16'hFC00;
  localparam logic [15:0] HP_QNAN    = 16'hFFFF;
  localparam logic [15:0] HP_ZERO    = 16'h0000;

  localparam logic [1:0] EXC_NONE = 2'b00;
  localparam logic [1:0] EXC_POS  = 2'b01;
  localparam logic [1:0] EXC_NEG  = 2'b10;
  localparam logic [1:0] EXC_NAN  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } acc_state_t;

  // Exception code of a raw operand: NaN, signed infinity or none.
  function automatic logic [1:0] hp_classify(input logic [15:0] v);
    if (&v[14:10]) begin
      if (|v[9:0]) return EXC_NAN;
      return v[15] ? EXC_NEG : EXC_POS;
    end
    return EXC_NONE;
  endfunction

endpackage

// File: rtl/hp_accumulator_if.sv
// Control, operand stream and result port bundle of hp_accumulator.
// The slave side is the accumulator, the master side its producer/consumer.
interface hp_accumulator_if #(
  parameter int LEN_W = 8
) ();

  logic             start;
  logic [LEN_W-1:0] vec_len;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      hp_in;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      hp_acc;
  logic [1:0]       Exceptions;
  logic [LEN_W-1:0] beats_left;

  modport master (
    output start, vec_len, in_valid, hp_in, out_ready,
    input  in_ready, out_valid, hp_acc, Exceptions, beats_left
  );

  modport slave (
    input  start, vec_len, in_valid, hp_in, out_ready,
    output in_ready, out_valid, hp_acc, Exceptions, beats_left
  );

endinterface

// File: rtl/hp_adder.sv
// Combinational half-precision adder, round-to-nearest-even,
// subnormals supported, NaN/inf/overflow reported on Exceptions.
module hp_adder
  import hp_pkg::*;
(
  input  logic [15:0] hp_inA,
  input  logic [15:0] hp_inB,
  output logic [15:0] hp_sum,
  output logic [1:0]  Exceptions
);

  logic        nan_a, nan_b, inf_a, inf_b;
  logic        sl, ss, sub, found, rnd;
  logic [15:0] big, sml;
  logic [10:0] ml, ms;
  logic [4:0]  el, es, d, dsh;
  logic [27:0] wide;
  logic [13:0] al, as, m;
  logic [14:0] sum;
  logic [6:0]  e;
  logic [3:0]  sh;
  logic [11:0] r;

  // Align, add, normalise, round and pack in one cone.
  always_comb begin
    nan_a = (&hp_inA[14:10]) && (|hp_inA[9:0]);
    nan_b = (&hp_inB[14:10]) && (|hp_inB[9:0]);
    inf_a = (&hp_inA[14:10]) && !(|hp_inA[9:0]);
    inf_b = (&hp_inB[14:10]) && !(|hp_inB[9:0]);
    if (hp_inA[14:0] >= hp_inB[14:0]) begin
      big = hp_inA;
      sml = hp_inB;
    end else begin
      big = hp_inB;
      sml = hp_inA;
    end
    sl  = big[15];
    ss  = sml[15];
    sub = sl ^ ss;
    ml  = {|big[14:10], big[9:0]};
    ms  = {|sml[14:10], sml[9:0]};
    el  = (big[14:10] == 5'd0) ? 5'd1 : big[14:10];
    es  = (sml[14:10] == 5'd0) ? 5'd1 : sml[14:10];
    d   = el - es;
    dsh = (d > 5'd17) ? 5'd17 : d;
    // small operand shifted right, lost bits folded into sticky
    wide = {ms, 17'd0} >> dsh;
    al   = {ml, 3'b000};
    as   = {wide[27:15], |wide[14:0]};
    sum  = sub ? ({1'b0, al} - {1'b0, as})
               : ({1'b0, al} + {1'b0, as});
    e     = {2'b00, el};
    sh    = 4'd0;
    found = 1'b0;
    if (sum[14]) begin
      m = {sum[14:2], sum[1] | sum[0]};
      e = e + 7'd1;
    end else begin
      m = sum[13:0];
      for (int i = 13; i >= 0; i--) begin
        if (!found) begin
          if (m[i]) found = 1'b1;
          else      sh = sh + 4'd1;
        end
      end
      // never normalise below the subnormal exponent
      if ({3'b000, sh} > e - 7'd1) sh = e[3:0] - 4'd1;
      m = m << sh;
      e = e - {3'b000, sh};
    end
    if (!m[13]) e = 7'd0;
    rnd = m[2] & (m[1] | m[0] | m[3]);
    r   = {1'b0, m[13:3]} + {11'd0, rnd};
    if (r[11]) begin
      r = r >> 1;
      e = e + 7'd1;
    end else if (e == 7'd0 && r[10]) begin
      e = 7'd1;
    end
    Exceptions = EXC_NONE;
    if (nan_a || nan_b || (inf_a && inf_b && (hp_inA[15] ^ hp_inB[15]))) begin
      hp_sum     = HP_QNAN;
      Exceptions = EXC_NAN;
    end else if (inf_a) begin
      hp_sum     = hp_inA;
      Exceptions = hp_inA[15] ? EXC_NEG : EXC_POS;
    end else if (inf_b) begin
      hp_sum     = hp_inB;
      Exceptions = hp_inB[15] ? EXC_NEG : EXC_POS;
    end else if (sum == 15'd0) begin
      hp_sum = HP_ZERO;
    end else if (e >= 7'd31) begin
      hp_sum     = sl ? HP_NEG_INF : HP_POS_INF;
      Exceptions = sl ? EXC_NEG : EXC_POS;
    end else begin
      hp_sum = {sl, e[4:0], r[9:0]};
    end
  end

endmodule

// File: rtl/hp_accumulator.sv
// Folds a programmed number of half-precision beats into one sum
// with sticky exception flags, result offered on a valid/ready port.
module hp_accumulator
  import hp_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input logic         clk,
  input logic         rst,
  hp_accumulator_if.slave bus
);

  acc_state_t       state_q, state_d;
  logic [15:0]      acc_q, acc_d;
  logic [1:0]       exc_q, exc_d;
  logic [LEN_W-1:0] beats_q, beats_d;
  logic             first_q, first_d;
  logic [15:0]      add_sum;
  logic [1:0]       add_exc;

  hp_adder u_adder (
    .hp_inA     (acc_q),
    .hp_inB     (bus.hp_in),
    .hp_sum     (add_sum),
    .Exceptions (add_exc)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= HP_ZERO;
      exc_q   <= EXC_NONE;
      beats_q <= '0;
      first_q <= 1'b1;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      exc_q   <= exc_d;
      beats_q <= beats_d;
      first_q <= first_d;
    end
  end

  // Next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start)
          state_d = (bus.vec_len != '0) ? S_ACCUM : S_DONE;
      end
      S_ACCUM: begin
        if (bus.in_valid && beats_q == LEN_W'(1))
          state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: load, first-beat bypass, add and sticky merge.
  always_comb begin
    acc_d   = acc_q;
    exc_d   = exc_q;
    beats_d = beats_q;
    first_d = first_q;
    if (state_q == S_IDLE && bus.start) begin
      if (bus.vec_len != '0) begin
        beats_d = bus.vec_len;
        first_d = 1'b1;
      end else begin
        acc_d = HP_ZERO;
        exc_d = EXC_NONE;
      end
    end else if (state_q == S_ACCUM && bus.in_valid) begin
      beats_d = beats_q - LEN_W'(1);
      first_d = 1'b0;
      if (first_q) begin
        acc_d = bus.hp_in;
        exc_d = hp_classify(bus.hp_in);
      end else begin
        acc_d = add_sum;
        if (add_exc == EXC_NAN)     exc_d = EXC_NAN;
        else if (exc_q == EXC_NONE) exc_d = add_exc;
      end
    end
  end

  // Moore outputs.
  always_comb begin
    bus.in_ready   = (state_q == S_ACCUM);
    bus.out_valid  = (state_q == S_DONE);
    bus.hp_acc     = acc_q;
    bus.Exceptions = exc_q;
    bus.beats_left = beats_q;
  end

endmodule

// File: tb/tb_hp_accumulator.sv
// Scenario bench for hp_accumulator with a result scoreboard.
// Expected sums come from constants or an exact small-integer model.
module tb_hp_accumulator;
  import hp_pkg::*;

  typedef struct packed {
    logic [15:0] acc;
    logic [1:0]  exc;
  } res_t;
  typedef logic [15:0] beat_q_t[$];

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  res_t sb[$];

  always #5 clk = ~clk;

  hp_accumulator_if #(.LEN_W(8)) bus ();

  hp_accumulator #(.LEN_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] int_to_hp(input int n);
    int p;
    logic [15:0] r;
    if (n == 0) return 16'h0000;
    p = 0;
    for (int i = 0; i < 16; i++)
      if (((n >> i) & 1) != 0) p = i;
    r[15]    = 1'b0;
    r[14:10] = 5'(p + 15);
    r[9:0]   = 10'((n << (10 - p)) & 'h3FF);
    return r;
  endfunction

  task automatic feed(input beat_q_t b, input bit tog, output int cyc);
    int idx;
    bit acc;
    idx = 0;
    cyc = 0;
    while (idx < b.size() && cyc < 200) begin
      bus.hp_in    = b[idx];
      bus.in_valid = tog ? 1'($urandom_range(0, 1)) : 1'b1;
      acc = bus.in_valid && bus.in_ready;
      tick;
      cyc++;
      if (acc) idx++;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cyc, output bit to);
    cyc = 0;
    while (!bus.out_valid && cyc < 50) begin
      tick;
      cyc++;
    end
    to = !bus.out_valid;
  endtask

  // start, feed all beats, wait for the result; returns observations
  task automatic reduce(input logic [7:0] len, input beat_q_t b,
                        input bit tog, output res_t got,
                        output int lat, output bit to);
    int c, w;
    bus.start   = 1'b1;
    bus.vec_len = len;
    tick;
    bus.start = 1'b0;
    feed(b, tog, c);
    wait_out(w, to);
    lat = 1 + c + w;
    got = {bus.hp_acc, bus.Exceptions};
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: rdy=%b vld=%b want 0/0",
               bus.in_ready, bus.out_valid);
    end
    checks++;
    if (bus.hp_acc !== 16'h0000) begin
      errors++;
      $display("FAIL reset_acc: got %h want 0000", bus.hp_acc);
    end
    checks++;
    if (bus.Exceptions !== 2'b00 || bus.beats_left !== 8'd0) begin
      errors++;
      $display("FAIL reset_exc_beats: got %b/%0d want 00/0",
               bus.Exceptions, bus.beats_left);
    end
    rst = 1'b0;
    tick;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.hp_acc !== 16'h0000) begin
      errors++;
      $display("FAIL reset_idle: vld=%b acc=%h want 0/0000",
               bus.out_valid, bus.hp_acc);
    end
  endtask

  task automatic test_two_beats;
    res_t got, exp;
    int lat;
    bit to;
    bus.out_ready = 1'b1;
    sb.push_back({16'h4B21, EXC_NONE});
    reduce(8'd2, '{16'h4A21, 16'h4000}, 1'b0, got, lat, to);
    checks++;
    if (to || lat != 3) begin
      errors++;
      $display("FAIL two_lat: got %0d (to=%b) want 3", lat, to);
    end
    exp = sb.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL two_res: got %h/%b want %h/%b",
               got.acc, got.exc, exp.acc, exp.exc);
    end
    tick;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 ||
        bus.hp_acc !== exp.acc) begin
      errors++;
      $display("FAIL two_idle_hold: vld=%b rdy=%b acc=%h want 0/0/%h",
               bus.out_valid, bus.in_ready, bus.hp_acc, exp.acc);
    end
  endtask

  task automatic test_single;
    res_t got, exp;
    int lat;
    bit to;
    sb.push_back({16'h3C00, EXC_NONE});
    reduce(8'd1, '{16'h3C00}, 1'b0, got, lat, to);
    checks++;
    if (to || lat != 2) begin
      errors++;
      $display("FAIL single_lat: got %0d (to=%b) want 2", lat, to);
    end
    exp = sb.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL single_res: got %h/%b want %h/%b",
               got.acc, got.exc, exp.acc, exp.exc);
    end
    tick;
  endtask

  task automatic test_nan_sticky;
    res_t exp;
    sb.push_back({HP_QNAN, EXC_NAN});
    bus.start   = 1'b1;
    bus.vec_len = 8'd3;
    tick;
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.hp_in    = 16'h7C00;
    tick;
    checks++;
    if (bus.Exceptions !== 2'b01 || bus.hp_acc !== 16'h7C00 ||
        bus.beats_left !== 8'd2) begin
      errors++;
      $display("FAIL nan_beat1: got %h/%b/%0d want 7c00/01/2",
               bus.hp_acc, bus.Exceptions, bus.beats_left);
    end
    bus.hp_in = 16'hFC00;
    tick;
    checks++;
    if (bus.Exceptions !== 2'b11 || bus.hp_acc !== 16'hFFFF) begin
      errors++;
      $display("FAIL nan_beat2: got %h/%b want ffff/11",
               bus.hp_acc, bus.Exceptions);
    end
    bus.hp_in = 16'h3C00;
    tick;
    bus.in_valid = 1'b0;
    exp = sb.pop_front();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.hp_acc !== exp.acc ||
        bus.Exceptions !== exp.exc) begin
      errors++;
      $display("FAIL nan_final: vld=%b got %h/%b want 1/%h/%b",
               bus.out_valid, bus.hp_acc, bus.Exceptions, exp.acc, exp.exc);
    end
    tick;
  endtask

  task automatic test_overflow;
    res_t got, exp;
    int lat;
    bit to;
    sb.push_back({HP_POS_INF, EXC_POS});
    reduce(8'd2, '{16'h7794, 16'h7B2A}, 1'b0, got, lat, to);
    exp = sb.pop_front();
    checks++;
    if (to || got !== exp) begin
      errors++;
      $display("FAIL ovf_res: got %h/%b (to=%b) want %h/%b",
               got.acc, got.exc, to, exp.acc, exp.exc);
    end
    tick;
  endtask

  task automatic test_zero_len;
    res_t got, exp;
    int lat;
    bit to;
    bus.out_ready = 1'b0;
    sb.push_back({HP_ZERO, EXC_NONE});
    reduce(8'd0, '{}, 1'b0, got, lat, to);
    exp = sb.pop_front();
    checks++;
    if (to || lat != 1 || got !== exp) begin
      errors++;
      $display("FAIL zero_res: lat=%0d got %h/%b want 1/%h/%b",
               lat, got.acc, got.exc, exp.acc, exp.exc);
    end
    for (int i = 0; i < 5; i++) begin
      bus.start    = (i == 1);
      bus.vec_len  = 8'd3;
      bus.in_valid = (i == 2);
      bus.hp_in    = 16'h3C00;
      tick;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          bus.hp_acc !== exp.acc || bus.Exceptions !== exp.exc ||
          bus.beats_left !== 8'd0) begin
        errors++;
        $display("FAIL zero_hold%0d: v=%b r=%b %h/%b/%0d want 1/0/%h/%b/0",
                 i, bus.out_valid, bus.in_ready, bus.hp_acc,
                 bus.Exceptions, bus.beats_left, exp.acc, exp.exc);
      end
    end
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_release: vld=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_reset_mid;
    res_t got, exp;
    int c, lat;
    bit to;
    bus.start   = 1'b1;
    bus.vec_len = 8'd4;
    tick;
    bus.start = 1'b0;
    feed('{16'h3C00, 16'h3C00}, 1'b1, c);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 ||
        bus.hp_acc !== 16'h0000 || bus.beats_left !== 8'd0 ||
        bus.Exceptions !== 2'b00) begin
      errors++;
      $display("FAIL rstmid: v=%b r=%b %h/%b/%0d want 0/0/0000/00/0",
               bus.out_valid, bus.in_ready, bus.hp_acc,
               bus.Exceptions, bus.beats_left);
    end
    sb.push_back({16'h4000, EXC_NONE});
    reduce(8'd1, '{16'h4000}, 1'b0, got, lat, to);
    exp = sb.pop_front();
    checks++;
    if (to || got !== exp) begin
      errors++;
      $display("FAIL rstmid_after: got %h/%b (to=%b) want %h/%b",
               got.acc, got.exc, to, exp.acc, exp.exc);
    end
    tick;
  endtask

  task automatic test_back_to_back;
    res_t got, exp;
    int lat, len, s, v;
    bit to;
    beat_q_t b;
    bus.out_ready = 1'b1;
    for (int r = 0; r < 6; r++) begin
      len = $urandom_range(1, 8);
      s = 0;
      b.delete();
      for (int k = 0; k < len; k++) begin
        v = $urandom_range(0, 15);
        s += v;
        b.push_back(int_to_hp(v));
      end
      sb.push_back({int_to_hp(s), EXC_NONE});
      reduce(8'(len), b, r[0], got, lat, to);
      exp = sb.pop_front();
      checks++;
      if (to || got !== exp) begin
        errors++;
        $display("FAIL b2b%0d: len=%0d got %h/%b (to=%b) want %h/%b",
                 r, len, got.acc, got.exc, to, exp.acc, exp.exc);
      end
      tick;
    end
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.vec_len   = '0;
    bus.in_valid  = 1'b0;
    bus.hp_in     = '0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    test_reset;
    test_two_beats;
    test_single;
    test_nan_sticky;
    test_overflow;
    test_zero_len;
    test_reset_mid;
    test_back_to_back;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_empty: %0d left want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
